// File: rtl/udp_sched_pkg.sv
// Shared types and constants for the UDP FIFO burst scheduler.
package udp_sched_pkg;

   // Scheduler FSM states.
   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      START     = 2'd1,
      XFER      = 2'd2,
      WAIT_DONE = 2'd3
   } sched_state_t;

   // Payload bytes carried by one FIFO read word.
   localparam int BYTES_PER_WORD = 2;

endpackage : udp_sched_pkg

// File: rtl/udp_fifo_burst_sched_flush_timer.sv
// Saturating idle counter that flags when a partial burst has waited long enough.
module flush_timer #(
   parameter int TIMER_WIDTH   = 16,
   parameter int FLUSH_TIMEOUT = 1000
) (
   input  logic clk,
   input  logic tb_rst,
   input  logic clr,
   input  logic inc,
   output logic expired
);

   localparam logic [TIMER_WIDTH-1:0] LIMIT = TIMER_WIDTH'(FLUSH_TIMEOUT);

   logic [TIMER_WIDTH-1:0] count_reg;

   // Count idle cycles; clear wins over increment, and the count parks at the limit.
   always_ff @(posedge clk or posedge tb_rst) begin
      if (tb_rst) begin
         count_reg <= '0;
      end else if (clr) begin
         count_reg <= '0;
      end else if (inc && (count_reg != LIMIT)) begin
         count_reg <= count_reg + 1'b1;
      end
   end

   assign expired = (count_reg == LIMIT);

endmodule : flush_timer

// File: rtl/udp_fifo_burst_sched.sv
// Read-side scheduler: launches a UDP frame per full (or timed-out partial)
// burst held in the FIFO and streams exactly that many words on tx_req.
module udp_fifo_burst_sched
   import udp_sched_pkg::*;
#(
   parameter int RD_DEPTH_WIDTH = 9,
   parameter int RD_DATA_WIDTH  = 16,
   parameter int BURST_WORDS    = 256,
   parameter int FLUSH_TIMEOUT  = 1000,
   parameter int TIMER_WIDTH    = 16
) (
   input  logic                      clk,
   input  logic                      tb_rst,
   input  logic                      enable,
   output logic                      fifo_rd_en,
   input  logic [RD_DATA_WIDTH-1:0]  fifo_rd_data,
   input  logic                      fifo_rd_empty,
   input  logic [RD_DEPTH_WIDTH:0]   fifo_rd_water_level,
   output logic                      tx_start_en,
   output logic [15:0]               tx_byte_num,
   input  logic                      tx_req,
   output logic [RD_DATA_WIDTH-1:0]  tx_data,
   output logic                      tx_data_vld,
   input  logic                      tx_done,
   output logic                      busy,
   output logic                      err
);

   localparam int LW = RD_DEPTH_WIDTH + 1;
   localparam logic [LW-1:0] BURST_LVL = LW'(BURST_WORDS);

   sched_state_t   state_reg, state_next;
   logic [LW-1:0]  len_reg;
   logic [LW-1:0]  cnt_reg;
   logic [15:0]    byte_num_reg;
   logic           start_reg;
   logic           vld_reg;
   logic           busy_reg;
   logic           err_reg;

   logic           full_lvl;
   logic           timer_expired;
   logic           timer_clr;
   logic           timer_inc;
   logic           trigger;
   logic [LW-1:0]  burst_len_next;
   logic           words_left;
   logic           rd_en_next;
   logic           err_next;

   // A full burst always takes precedence over a timed-out partial one.
   assign full_lvl       = (fifo_rd_water_level >= BURST_LVL);
   assign burst_len_next = full_lvl ? BURST_LVL : fifo_rd_water_level;
   assign trigger        = enable && (full_lvl || (timer_expired && !fifo_rd_empty));
   assign words_left     = (cnt_reg < len_reg);

   // Timer only runs while idling on a partial, non-empty FIFO.
   assign timer_clr = (state_reg != IDLE) || fifo_rd_empty;
   assign timer_inc = (state_reg == IDLE) && !fifo_rd_empty && !full_lvl;

   flush_timer #(
      .TIMER_WIDTH   (TIMER_WIDTH),
      .FLUSH_TIMEOUT (FLUSH_TIMEOUT)
   ) u_flush_timer (
      .clk     (clk),
      .tb_rst  (tb_rst),
      .clr     (timer_clr),
      .inc     (timer_inc),
      .expired (timer_expired)
   );

   // Next-state, combinational read enable and protocol-error detection.
   always_comb begin
      state_next = state_reg;
      rd_en_next = 1'b0;
      err_next   = 1'b0;
      case (state_reg)
         IDLE: begin
            if (trigger) state_next = START;
         end
         START: begin
            state_next = XFER;
         end
         XFER: begin
            if (tx_req && words_left && !fifo_rd_empty) rd_en_next = 1'b1;
            if (tx_req && words_left && fifo_rd_empty)  err_next   = 1'b1;
            if (tx_req && !words_left)                  err_next   = 1'b1;
            if (!words_left)                            state_next = WAIT_DONE;
         end
         WAIT_DONE: begin
            if (tx_req && !words_left) err_next   = 1'b1;
            if (tx_done)               state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
      if (tx_done && (state_reg != WAIT_DONE)) err_next = 1'b1;
   end

   // State register plus registered status outputs.
   always_ff @(posedge clk or posedge tb_rst) begin
      if (tb_rst) begin
         state_reg <= IDLE;
         start_reg <= 1'b0;
         vld_reg   <= 1'b0;
         busy_reg  <= 1'b0;
         err_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         start_reg <= (state_next == START);
         vld_reg   <= rd_en_next;
         busy_reg  <= (state_next != IDLE);
         err_reg   <= err_reg | err_next;
      end
   end

   // Burst length and byte count are captured as the burst is launched and held until the next one.
   always_ff @(posedge clk or posedge tb_rst) begin
      if (tb_rst) begin
         len_reg      <= '0;
         cnt_reg      <= '0;
         byte_num_reg <= '0;
      end else if ((state_reg == IDLE) && trigger) begin
         len_reg      <= burst_len_next;
         cnt_reg      <= '0;
         byte_num_reg <= 16'(burst_len_next) * 16'(BYTES_PER_WORD);
      end else if (rd_en_next) begin
         cnt_reg      <= cnt_reg + 1'b1;
      end
   end

   assign fifo_rd_en  = rd_en_next;
   assign tx_start_en = start_reg;
   assign tx_byte_num = byte_num_reg;
   assign tx_data_vld = vld_reg;
   // FIFO data arrives one cycle after the read; masked so idle data is zero.
   assign tx_data     = vld_reg ? fifo_rd_data : '0;
   assign busy        = busy_reg;
   assign err         = err_reg;

endmodule : udp_fifo_burst_sched

// File: tb/tb_udp_fifo_burst_sched.sv
// Scoreboard bench: FIFO model + UDP engine model drive the scheduler; a monitor
// checks start byte counts, payload order and per-frame word counts.
module tb_udp_fifo_burst_sched;

   localparam int DW    = 9;
   localparam int DATAW = 16;
   localparam int BURST = 256;
   localparam int FLUSH = 600;

   logic             clk = 1'b0;
   logic             tb_rst;
   logic             enable;
   logic             fifo_rd_en;
   logic [DATAW-1:0] fifo_rd_data;
   logic             fifo_rd_empty;
   logic [DW:0]      fifo_rd_water_level;
   logic             tx_start_en;
   logic [15:0]      tx_byte_num;
   logic             tx_req;
   logic [DATAW-1:0] tx_data;
   logic             tx_data_vld;
   logic             tx_done;
   logic             busy;
   logic             err;

   udp_fifo_burst_sched #(
      .RD_DEPTH_WIDTH (DW),
      .RD_DATA_WIDTH  (DATAW),
      .BURST_WORDS    (BURST),
      .FLUSH_TIMEOUT  (FLUSH),
      .TIMER_WIDTH    (16)
   ) dut (
      .clk                 (clk),
      .tb_rst              (tb_rst),
      .enable              (enable),
      .fifo_rd_en          (fifo_rd_en),
      .fifo_rd_data        (fifo_rd_data),
      .fifo_rd_empty       (fifo_rd_empty),
      .fifo_rd_water_level (fifo_rd_water_level),
      .tx_start_en         (tx_start_en),
      .tx_byte_num         (tx_byte_num),
      .tx_req              (tx_req),
      .tx_data             (tx_data),
      .tx_data_vld         (tx_data_vld),
      .tx_done             (tx_done),
      .busy                (busy),
      .err                 (err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int start_count = 0;

   logic [DATAW-1:0] fifo_q[$];
   logic [DATAW-1:0] pend_q[$];
   logic [DATAW-1:0] exp_data_q[$];
   int               exp_len_q[$];

   logic [DATAW-1:0] rd_data_r = '0;
   logic [DW:0]      level_r   = '0;

   assign fifo_rd_data        = rd_data_r;
   assign fifo_rd_water_level = level_r;
   assign fifo_rd_empty       = (level_r == '0);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Behavioural FIFO: read data appears the cycle after fifo_rd_en, writes land on the edge.
   always @(posedge clk) begin
      if (fifo_rd_en && (fifo_q.size() > 0)) rd_data_r <= fifo_q.pop_front();
      while (pend_q.size() > 0) fifo_q.push_back(pend_q.pop_front());
      level_r <= (DW+1)'(fifo_q.size());
   end

   // Monitor: pops expectations whenever the DUT presents a start or a data word.
   initial begin
      int exp_bytes;
      int cur_words;
      int seen;
      bit in_burst;
      in_burst = 0; cur_words = 0; seen = 0;
      forever begin
         @(negedge clk);
         if (tb_rst) begin
            in_burst = 0;
         end else begin
            if (tx_start_en) begin
               start_count++;
               if (exp_len_q.size() == 0) begin
                  chk("unexpected_start", 32'(tx_byte_num), 32'hFFFF_FFFF);
               end else begin
                  exp_bytes = exp_len_q.pop_front();
                  chk("tx_byte_num", 32'(tx_byte_num), 32'(exp_bytes));
                  cur_words = exp_bytes / 2;
               end
               seen = 0;
               in_burst = 1;
            end
            if (tx_data_vld) begin
               seen++;
               if (exp_data_q.size() == 0) chk("unexpected_word", 32'(tx_data), 32'hFFFF_FFFF);
               else chk("tx_data", 32'(tx_data), 32'(exp_data_q.pop_front()));
            end
            if (tx_done && in_burst) begin
               chk("words_per_frame", 32'(seen), 32'(cur_words));
               in_burst = 0;
            end
         end
      end
   end

   task automatic write_words(input int n);
      logic [DATAW-1:0] w;
      for (int i = 0; i < n; i++) begin
         w = DATAW'($urandom);
         pend_q.push_back(w);
         exp_data_q.push_back(w);
      end
   endtask

   // Returns the number of negedges until tx_start_en is seen, or -1 on timeout.
   task automatic wait_start(input int bound, output int cycles);
      int c;
      c = 0;
      cycles = -1;
      while (c < bound) begin
         @(negedge clk);
         c++;
         if (tx_start_en) begin
            cycles = c;
            return;
         end
      end
   endtask

   // UDP engine: nreq request cycles (optionally with random gaps), then tx_done.
   task automatic run_engine(input int nreq, input int gap_max);
      for (int i = 0; i < nreq; i++) begin
         tx_req = 1'b1;
         @(negedge clk);
         if (gap_max > 0) begin
            tx_req = 1'b0;
            repeat ($urandom_range(0, gap_max)) @(negedge clk);
         end
      end
      tx_req = 1'b0;
      repeat (3) @(negedge clk);
      tx_done = 1'b1;
      @(negedge clk);
      tx_done = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_rd_en"},    32'(fifo_rd_en),  32'd0);
      chk({tag, "_start"},    32'(tx_start_en), 32'd0);
      chk({tag, "_vld"},      32'(tx_data_vld), 32'd0);
      chk({tag, "_busy"},     32'(busy),        32'd0);
      chk({tag, "_err"},      32'(err),         32'd0);
      chk({tag, "_byte_num"}, 32'(tx_byte_num), 32'd0);
      chk({tag, "_tx_data"},  32'(tx_data),     32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      int snap;
      tb_rst = 1'b1; enable = 1'b1; tx_req = 1'b0; tx_done = 1'b0;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      tb_rst = 1'b0;
      repeat (2) @(negedge clk);

      // Full burst with random request gaps; level crossing to start is 2 cycles.
      exp_len_q.push_back(512);
      write_words(256);
      wait_start(10, cyc);
      chk("full_latency", 32'(cyc), 32'd2);
      chk("busy_in_start", 32'(busy), 32'd1);
      @(negedge clk);
      run_engine(256, 2);
      chk("full_err", 32'(err), 32'd0);

      // Flush of 5 words: start FLUSH+1 cycles after the first non-empty idle cycle.
      exp_len_q.push_back(10);
      write_words(5);
      wait_start(FLUSH + 20, cyc);
      chk("flush_latency", 32'(cyc), 32'(FLUSH + 2));
      @(negedge clk);
      run_engine(5, 1);

      // Level parked at 100 below the timeout, then raised past a full burst.
      write_words(100);
      snap = start_count;
      repeat (500) @(negedge clk);
      chk("no_start_at_100", 32'(start_count - snap), 32'd0);
      exp_len_q.push_back(512);
      write_words(166);
      wait_start(10, cyc);
      chk("cross_latency", 32'(cyc), 32'd2);
      @(negedge clk);
      run_engine(256, 0);
      // 10 leftover words: timer must restart from zero after the burst.
      exp_len_q.push_back(20);
      wait_start(FLUSH + 20, cyc);
      chk("timer_cleared", 32'(cyc), 32'(FLUSH + 1));
      @(negedge clk);
      run_engine(10, 0);

      // Reset in the middle of a transfer after 100 words.
      exp_len_q.push_back(512);
      write_words(256);
      wait_start(10, cyc);
      chk("rst_burst_latency", 32'(cyc), 32'd2);
      @(negedge clk);
      for (int i = 0; i < 100; i++) begin
         tx_req = 1'b1;
         @(negedge clk);
      end
      tx_req = 1'b0;
      repeat (2) @(negedge clk);
      tx_req = 1'b1;
      tb_rst = 1'b1;
      #1;
      check_all_zero("midrst");
      repeat (3) @(negedge clk);
      tx_req = 1'b0;
      tb_rst = 1'b0;
      exp_len_q.push_back(312);
      wait_start(FLUSH + 20, cyc);
      chk("post_rst_start_seen", 32'(cyc > 0), 32'd1);
      @(negedge clk);
      run_engine(156, 1);

      // enable dropped mid-burst: current burst finishes, no new burst while low.
      exp_len_q.push_back(512);
      write_words(256);
      wait_start(10, cyc);
      chk("dis_latency", 32'(cyc), 32'd2);
      @(negedge clk);
      for (int i = 0; i < 50; i++) begin
         tx_req = 1'b1;
         @(negedge clk);
      end
      enable = 1'b0;
      run_engine(206, 2);
      write_words(300);
      snap = start_count;
      repeat (300) @(negedge clk);
      chk("no_start_disabled", 32'(start_count - snap), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
      exp_len_q.push_back(512);
      enable = 1'b1;
      wait_start(10, cyc);
      chk("enable_latency", 32'(cyc), 32'd1);
      @(negedge clk);
      run_engine(256, 0);

      // Excess requests: 260 requests on a 256-word burst.
      chk("pre_excess_err", 32'(err), 32'd0);
      exp_len_q.push_back(512);
      write_words(212);
      wait_start(10, cyc);
      chk("excess_latency", 32'(cyc), 32'd2);
      @(negedge clk);
      run_engine(260, 0);
      chk("excess_err", 32'(err), 32'd1);

      // Stray tx_done in IDLE after clearing err with reset.
      tb_rst = 1'b1;
      repeat (3) @(negedge clk);
      tb_rst = 1'b0;
      @(negedge clk);
      chk("err_cleared", 32'(err), 32'd0);
      tx_done = 1'b1;
      @(negedge clk);
      tx_done = 1'b0;
      @(negedge clk);
      chk("stray_done_err", 32'(err), 32'd1);
      repeat (5) @(negedge clk);
      chk("err_sticky", 32'(err), 32'd1);
      chk("exp_len_drained", 32'(exp_len_q.size()), 32'd0);
      chk("exp_data_drained", 32'(exp_data_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_udp_fifo_burst_sched
